alu_wb_queue: RTL
=================

# alu_wb_queue

Writeback queue that sits directly downstream of the ALU in the execute stage. It captures each ALU result with its destination register in a small in-order FIFO and drains entries to the register-file write port under a valid/ready handshake. Combinational lookup ports return the youngest pending value for a register, so decode can bypass values that have not yet been written back. A flush input discards all pending results on a branch or jump squash.

## Interface
- WORD_SIZE, 16, data width; matches the ALU result width.
- DEPTH, 4, number of queue entries; power of two, 2 or greater.
- REG_ADDR, 2, destination register index width (4 GPRs).
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- push_valid  input  1  ALU result presented this cycle.
- push_ready  output  1  queue can accept a push this cycle.
- push_dest  input  REG_ADDR  destination register of the ALU result.
- push_data  input  WORD_SIZE  ALU result value.
- wb_valid  output  1  head entry is available for writeback.
- wb_ready  input  1  register-file write port is free this cycle.
- wb_dest  output  REG_ADDR  head destination register; 0 when empty.
- wb_data  output  WORD_SIZE  head value; 0 when empty.
- lookup_addr1 / lookup_addr2  input  REG_ADDR  registers being read by decode.
- lookup_hit1 / lookup_hit2  output  1  a pending entry targets the corresponding address.
- lookup_data1 / lookup_data2  output  WORD_SIZE  value of the youngest matching entry; 0 on a miss.
- flush  input  1  discard all entries.
- count  output  $clog2(DEPTH)+1  number of valid entries.

## Operation
- State: DEPTH-entry array of {dest, data}, a head pointer, a tail pointer (both log2(DEPTH) bits, wrapping modulo DEPTH), and count.
- Push fires when push_valid && push_ready. The entry is written at tail, and tail advances.
- Pop fires when wb_valid && wb_ready. Head advances.
- wb_valid = (count != 0). wb_dest and wb_data are read combinationally from the head entry and forced to 0 when the queue is empty.
- push_ready = (count < DEPTH) || (wb_valid && wb_ready). A push is therefore allowed into a full queue in the same cycle as a pop.
- count update: push only, +1; pop only, −1; both or neither, unchanged.
- Pushes while push_ready is low are ignored, with no state change. Pops while the queue is empty cannot occur because wb_valid is low.
- Lookup (each port independent and purely combinational):
  - Scans only valid entries and selects the youngest (closest to tail) entry whose dest matches.
  - The head entry being popped this cycle is still visible.
  - The value being pushed this cycle is not visible until the next cycle.
- flush has priority over push and pop. On the next edge, head, tail and count return to 0, and any push or pop in the flush cycle is discarded. wb_valid may still be high during the flush cycle, and the register file must ignore it.
- reset behaves identically to flush. Entry array contents are don't-care.

## Timing
- Reset values: count 0, wb_valid 0, wb_dest 0, wb_data 0, push_ready 1, lookup_hit1/2 0, lookup_data1/2 0.
- Latency: a result pushed at edge N appears at the head (if the queue was empty) and in lookups in the cycle after edge N.
- Minimum residency is one cycle, so there is no combinational push-to-wb path. push_ready depends combinationally on wb_ready.
- Pointers wrap from DEPTH−1 to 0 with no bubble.
- Sustained throughput is one push plus one pop per cycle with the queue at any occupancy.

## Test plan
- Reset, then push {dest 1, 0x1234} with wb_ready=0 → count=1, wb_valid=1, wb_dest=1, wb_data=0x1234; lookup_addr1=1 → hit1=1, data1=0x1234; lookup_addr2=2 → hit2=0, data2=0.
- Push dest 2/0xAAAA then dest 2/0x5555 with wb_ready=0 → lookup on reg 2 returns 0x5555. Pop once → still 0x5555. Pop again → hit=0.
- Fill the queue with 4 pushes (count=4, push_ready=0), then attempt a push with wb_ready=0 → ignored, count stays 4. Next cycle push 0x00FF with wb_ready=1 → count stays 4, head advances, 0x00FF becomes the tail entry.
- Stream 10 pushes with wb_ready=1 every cycle → wb_data order equals push order across pointer wrap, and count never exceeds 1.
- Queue holding 3 entries; assert flush together with push_valid and wb_ready → next cycle count=0, wb_valid=0, all lookups miss, and the flushed push never appears.
- Assert reset with 2 entries pending and push_valid=1 → next cycle count=0, wb_valid=0, wb_data=0, push_ready=1.

Source files
------------

// File: rtl/alu_wb_queue_if.sv
// alu_wb_queue_if
//   Bundle between the execute stage, the writeback queue, the register-file
//   write port and the decode bypass lookups.
//   slave  : the queue side (accepts pushes, presents writeback, answers lookups)
//   master : the surrounding pipeline (ALU, register file, decode, squash)
//   Signals: push_valid/push_ready/push_dest/push_data  ALU result handshake
//            wb_valid/wb_ready/wb_dest/wb_data          writeback handshake
//            lookup_addr{1,2} -> lookup_hit{1,2}, lookup_data{1,2}
//            flush (squash), count (occupancy)
interface alu_wb_queue_if #(
    parameter int WORD_SIZE = 16,
    parameter int DEPTH     = 4,
    parameter int REG_ADDR  = 2
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic                 push_valid;
    logic                 push_ready;
    logic [REG_ADDR-1:0]  push_dest;
    logic [WORD_SIZE-1:0] push_data;

    logic                 wb_valid;
    logic                 wb_ready;
    logic [REG_ADDR-1:0]  wb_dest;
    logic [WORD_SIZE-1:0] wb_data;

    logic [REG_ADDR-1:0]  lookup_addr1;
    logic [REG_ADDR-1:0]  lookup_addr2;
    logic                 lookup_hit1;
    logic                 lookup_hit2;
    logic [WORD_SIZE-1:0] lookup_data1;
    logic [WORD_SIZE-1:0] lookup_data2;

    logic                 flush;
    logic [CNT_W-1:0]     count;

    modport slave (
        input  push_valid, push_dest, push_data, wb_ready,
               lookup_addr1, lookup_addr2, flush,
        output push_ready, wb_valid, wb_dest, wb_data,
               lookup_hit1, lookup_hit2, lookup_data1, lookup_data2, count
    );

    modport master (
        output push_valid, push_dest, push_data, wb_ready,
               lookup_addr1, lookup_addr2, flush,
        input  push_ready, wb_valid, wb_dest, wb_data,
               lookup_hit1, lookup_hit2, lookup_data1, lookup_data2, count
    );
endinterface

// File: rtl/alu_wb_queue.sv
// alu_wb_queue
//   In-order FIFO of {dest, data} ALU results draining to the register-file
//   write port, with two combinational bypass lookups returning the youngest
//   pending value for a register.
//   Ports: clk    rising-edge clock
//          reset  synchronous active-high reset (same effect as flush)
//          q      alu_wb_queue_if.slave (push, writeback, lookup, flush, count)
module alu_wb_queue #(
    parameter int WORD_SIZE = 16,
    parameter int DEPTH     = 4,
    parameter int REG_ADDR  = 2
) (
    input  logic         clk,
    input  logic         reset,
    alu_wb_queue_if.slave q
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    typedef struct packed {
        logic [REG_ADDR-1:0]  dest;
        logic [WORD_SIZE-1:0] data;
    } entry_t;

    entry_t [DEPTH-1:0] mem_q, mem_d;
    logic   [PTR_W-1:0] head_q, head_d;
    logic   [PTR_W-1:0] tail_q, tail_d;
    logic   [CNT_W-1:0] count_q, count_d;

    logic wb_valid;
    logic push_ready;
    logic push_fire;
    logic pop_fire;

    // Handshake and head presentation
    always_comb begin
        wb_valid   = (count_q != '0);
        // A full queue still accepts a push when the head drains this cycle.
        push_ready = (count_q < FULL) || (wb_valid && q.wb_ready);
        push_fire  = q.push_valid && push_ready;
        pop_fire   = wb_valid && q.wb_ready;
    end

    assign q.wb_valid   = wb_valid;
    assign q.push_ready = push_ready;
    assign q.wb_dest    = wb_valid ? mem_q[head_q].dest : '0;
    assign q.wb_data    = wb_valid ? mem_q[head_q].data : '0;
    assign q.count      = count_q;

    // Next state; flush discards any push/pop in the same cycle.
    always_comb begin
        mem_d   = mem_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (q.flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (push_fire) begin
                mem_d[tail_q] = '{dest: q.push_dest, data: q.push_data};
                tail_d        = tail_q + 1'b1;
            end
            if (pop_fire) begin
                head_d = head_q + 1'b1;
            end
            case ({push_fire, pop_fire})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Entry storage needs no reset: only slots below count are ever read.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    // Bypass lookups: walk from head (oldest) towards tail so the last match
    // seen is the youngest. Only registered state is scanned, so a value
    // pushed this cycle is not visible and a head being popped still is.
    logic [1:0][REG_ADDR-1:0] lk_addr;
    assign lk_addr = {q.lookup_addr2, q.lookup_addr1};

    for (genvar p = 0; p < 2; p++) begin : g_lk
        logic                 hit;
        logic [WORD_SIZE-1:0] data;
        always_comb begin
            hit  = 1'b0;
            data = '0;
            for (int k = 0; k < DEPTH; k++) begin
                if ((CNT_W'(k) < count_q) &&
                    (mem_q[head_q + PTR_W'(k)].dest == lk_addr[p])) begin
                    hit  = 1'b1;
                    data = mem_q[head_q + PTR_W'(k)].data;
                end
            end
        end
    end

    assign q.lookup_hit1  = g_lk[0].hit;
    assign q.lookup_data1 = g_lk[0].data;
    assign q.lookup_hit2  = g_lk[1].hit;
    assign q.lookup_data2 = g_lk[1].data;
endmodule
